reg_writeback_ctrl: RTL and testbench
=====================================

// Module: reg_writeback_ctrl
// PURPOSE
// - Write side of the 32x32 integer register file: merges ALU results and load responses into one write port.
// - Tracks in-flight loads in an in-order queue and sign/zero-extends load data per funct3.
// - Drives reg_write/rd_addr/rd_data to the register file; optional scoreboard flags pending-load destinations.
// PARAMETERS
// - LDQ_DEPTH  4  outstanding-load queue entries (power of 2, >=2)
// PORTS
// - clk            in   1   clock, all state on rising edge
// - rst_n          in   1   synchronous reset, active low
// - alu_valid      in   1   ALU result available this cycle
// - alu_rd         in   5   ALU destination register
// - alu_result     in   32  ALU result
// - alu_ready      out  1   ALU write accepted this cycle
// - ld_issue_valid in   1   load issued to data memory
// - ld_issue_rd    in   5   load destination register
// - ld_funct3      in   3   load type (instruction[14:12])
// - ld_addr_lo     in   2   effective address bits [1:0]
// - ld_issue_ready out  1   queue can accept the issue
// - mem_rsp_valid  in   1   data memory returns a word (in issue order, cannot be stalled)
// - mem_rsp_data   in   32  raw aligned memory word
// - reg_write      out  1   register file write enable
// - rd_addr        out  5   register file write address
// - rd_data        out  32  register file write data
// - busy_mask      out  32  bit n set = load pending to xn
// - rsp_err        out  1   sticky: response arrived with queue empty
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): reg_write=0, rd_addr=0, rd_data=0, rsp_err=0, queue empty, busy_mask=0.
// - Write port registered: an accepted source in cycle N appears on reg_write/rd_addr/rd_data in cycle N+1.
// - reg_write is high for exactly one cycle per accepted write; otherwise 0. rd_addr/rd_data hold last value.
// - Priority: mem_rsp_valid wins; alu_ready = !(mem_rsp_valid && queue non-empty). Idle ALU -> alu_ready=1.
// - ALU write accepted when alu_valid && alu_ready; producer holds alu_* stable until accepted.
// - Issue accepted when ld_issue_valid && ld_issue_ready; ld_issue_ready = !full || mem_rsp_valid.
//   Push {rd, funct3, addr_lo} at tail. Simultaneous push+pop when full is legal; count unchanged.
// - Response pops head entry; extension on head fields, byte lane b=addr_lo, half lane h=addr_lo[1]:
//   000 LB  sext(byte b); 001 LH sext(half h); 010 LW word; 100 LBU zext(byte b); 101 LHU zext(half h);
//   011/110/111 treated as LW. Misaligned LH/LHU/LW use lane above with no trap.
// - rd==0 (ALU or load): source accepted and popped normally, but reg_write stays 0 next cycle.
// - mem_rsp_valid with queue empty: ignored, no write, rsp_err set until reset.
// - Pointers wrap modulo LDQ_DEPTH; full/empty from a count of width clog2(LDQ_DEPTH)+1.
// - Reset mid-operation discards all queued loads; later responses for them raise rsp_err.
// CONFIGURATION
// - WB_SCOREBOARD_EN defined: busy_mask[n] = OR over valid queue entries with rd==n (n!=0), combinational
//   from queue state; bit set the cycle after issue accept, cleared the cycle after the last matching pop.
//   Two pending loads to same rd keep the bit set until both pop.
// - WB_SCOREBOARD_EN undefined: busy_mask tied to 32'h0, no comparator logic.
// TESTING
// - ALU only: alu_valid=1, rd=5, result=32'hDEADBEEF -> next cycle reg_write=1, rd_addr=5, rd_data=DEADBEEF.
// - Loads: LB addr_lo=3 on 32'h80FF_0000 -> rd_data=32'hFFFFFF80; LHU addr_lo=2 same word -> 32'h000080FF.
// - Collision: mem_rsp_valid and alu_valid in same cycle -> alu_ready=0, load written first, ALU next cycle.
// - Full queue: 4 issues, 5th held (ld_issue_ready=0) until a response; issue+response same cycle accepted.
// - rd=0 ALU write and load response -> reg_write stays 0; a response with empty queue -> rsp_err=1.
// - WB_SCOREBOARD_EN: two loads to x7 -> busy_mask[7]=1 until second response pops, then 0.

Source files
------------

// File: rtl/reg_writeback_ctrl.sv
// Register-file write side: merges ALU results and in-order load responses into one write port.
// Optional pending-load scoreboard on busy_mask is enabled by defining WB_SCOREBOARD_EN.
module reg_writeback_ctrl #(
    parameter int LDQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        ld_issue_valid,
    input  logic [4:0]  ld_issue_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    output logic        ld_issue_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        reg_write,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] busy_mask,
    output logic        rsp_err
);
    localparam int AW = $clog2(LDQ_DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_q_rd [LDQ_DEPTH];
    logic [2:0]    r_q_f3 [LDQ_DEPTH];
    logic [1:0]    r_q_lo [LDQ_DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_alu_acc;
    logic [4:0]    w_h_rd;
    logic [2:0]    w_h_f3;
    logic [1:0]    w_h_lo;
    logic [31:0]   w_shift;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ld_data;

    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == CW'(LDQ_DEPTH));
    assign w_pop          = mem_rsp_valid && !w_empty;
    assign alu_ready      = !w_pop;
    assign ld_issue_ready = !w_full || mem_rsp_valid;
    assign w_push         = ld_issue_valid && ld_issue_ready;
    assign w_alu_acc      = alu_valid && alu_ready;

    assign w_h_rd = r_q_rd[r_head];
    assign w_h_f3 = r_q_f3[r_head];
    assign w_h_lo = r_q_lo[r_head];

    // Lane selection: misaligned half/word accesses simply take the lane the low bits point at.
    assign w_shift = mem_rsp_data >> {w_h_lo, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = w_h_lo[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

    always_comb begin
        w_ld_data = mem_rsp_data;
        case (w_h_f3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b101:  w_ld_data = {16'h0, w_half};
            default: w_ld_data = mem_rsp_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_q_rd[r_tail] <= ld_issue_rd;
            r_q_f3[r_tail] <= ld_funct3;
            r_q_lo[r_tail] <= ld_addr_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            reg_write <= 1'b0;
            rd_addr   <= 5'd0;
            rd_data   <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            reg_write <= 1'b0;
            // x0 destinations consume their slot but never reach the register file.
            if (w_pop) begin
                if (w_h_rd != 5'd0) begin
                    reg_write <= 1'b1;
                    rd_addr   <= w_h_rd;
                    rd_data   <= w_ld_data;
                end
            end else if (w_alu_acc && alu_rd != 5'd0) begin
                reg_write <= 1'b1;
                rd_addr   <= alu_rd;
                rd_data   <= alu_result;
            end
            if (mem_rsp_valid && w_empty)
                rsp_err <= 1'b1;
            if (w_pop)
                r_head <= r_head + AW'(1);
            if (w_push)
                r_tail <= r_tail + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [LDQ_DEPTH-1:0] w_valid;
    genvar gi, gn;
    generate
        for (gi = 0; gi < LDQ_DEPTH; gi++) begin : g_valid
            logic [AW-1:0] w_off;
            assign w_off       = AW'(gi) - r_head;
            assign w_valid[gi] = ({1'b0, w_off} < r_count);
        end
        for (gn = 0; gn < 32; gn++) begin : g_busy
            if (gn == 0) begin : g_zero
                assign busy_mask[gn] = 1'b0;
            end else begin : g_cmp
                logic [LDQ_DEPTH-1:0] w_hit;
                for (gi = 0; gi < LDQ_DEPTH; gi++) begin : g_hit
                    assign w_hit[gi] = w_valid[gi] && (r_q_rd[gi] == 5'(gn));
                end
                assign busy_mask[gn] = |w_hit;
            end
        end
    endgenerate
`else
    assign busy_mask = 32'h0;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios then constrained-random traffic against a queue model.
module tb_reg_writeback_ctrl;
    localparam int LDQ_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        alu_ready;
    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        ld_issue_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] busy_mask;
    logic        rsp_err;

    reg_writeback_ctrl #(.LDQ_DEPTH(LDQ_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
        .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_funct3(ld_funct3),
        .ld_addr_lo(ld_addr_lo), .ld_issue_ready(ld_issue_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy_mask(busy_mask), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] lo;
    } ld_t;

    ld_t         ldq[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_err;
    int          nchk = 0;
    int          nerr = 0;
    logic        a_acc, i_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Extension from first principles: pick the lane numerically, then sign-adjust by value range.
    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(lo))) & 32'hFF;
        h = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = 32'h0;
`ifdef WB_SCOREBOARD_EN
        foreach (ldq[k]) if (ldq[k].rd != 5'd0) m[ldq[k].rd] = 1'b1;
`endif
        return m;
    endfunction

    task automatic cycle(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] ares,
                         input logic iv, input logic [4:0] ird, input logic [2:0] f3, input logic [1:0] lo,
                         input logic rv, input logic [31:0] rdat,
                         output logic alu_acc, output logic iss_acc);
        logic e_ar, e_ir;
        ld_t  e;
        @(negedge clk);
        rst_n = !rst; alu_valid = av; alu_rd = ard; alu_result = ares;
        ld_issue_valid = iv; ld_issue_rd = ird; ld_funct3 = f3; ld_addr_lo = lo;
        mem_rsp_valid = rv; mem_rsp_data = rdat;
        #1;
        e_ar = !(rv && ldq.size() > 0);
        e_ir = (ldq.size() < LDQ_DEPTH) || rv;
        if (!rst) begin
            chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_ar});
            chk("ld_issue_ready", {31'd0, ld_issue_ready}, {31'd0, e_ir});
            chk("busy_mask_pre", busy_mask, model_busy());
        end
        alu_acc = !rst && av && e_ar;
        iss_acc = !rst && iv && e_ir;
        if (rst) begin
            ldq.delete();
            m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_err = 1'b0;
        end else begin
            m_we = 1'b0;
            if (rv && ldq.size() > 0) begin
                e = ldq.pop_front();
                if (e.rd != 5'd0) begin
                    m_we = 1'b1; m_addr = e.rd; m_data = ext(e.f3, e.lo, rdat);
                end
            end else begin
                if (rv) m_err = 1'b1;
                if (alu_acc && ard != 5'd0) begin
                    m_we = 1'b1; m_addr = ard; m_data = ares;
                end
            end
            if (iss_acc) ldq.push_back('{rd: ird, f3: f3, lo: lo});
        end
        @(posedge clk);
        #1;
        chk("reg_write", {31'd0, reg_write}, {31'd0, m_we});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        chk("busy_mask_post", busy_mask, model_busy());
        if (m_we || rst) begin
            chk("rd_addr", {27'd0, rd_addr}, {27'd0, m_addr});
            chk("rd_data", rd_data, m_data);
        end
        if (m_we) $display("write x%0d = %h", m_addr, m_data);
    endtask

    logic        r_av;
    logic [4:0]  r_ard;
    logic [31:0] r_ares;
    logic        r_iv;
    logic [4:0]  r_ird;
    logic [2:0]  r_f3;
    logic [1:0]  r_lo;
    logic        r_rv;

    initial begin
        // Reset state
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, a_acc, i_acc);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, a_acc, i_acc);
        chk("reset_rd_data", rd_data, 32'h0);
        // ALU only
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, a_acc, i_acc);
        chk("alu_const", rd_data, 32'hDEADBEEF);
        // LB lane 3 and LHU lane 2
        cycle(0, 0, 0, 0, 1, 3, 3'b000, 2'd3, 0, 0, a_acc, i_acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000, a_acc, i_acc);
        chk("lb_const", rd_data, 32'hFFFFFF80);
        cycle(0, 0, 0, 0, 1, 4, 3'b101, 2'd2, 0, 0, a_acc, i_acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_0000, a_acc, i_acc);
        chk("lhu_const", rd_data, 32'h000080FF);
        // Collision: load wins, ALU follows
        cycle(0, 0, 0, 0, 1, 6, 3'b010, 2'd0, 0, 0, a_acc, i_acc);
        cycle(0, 1, 8, 32'h1234_5678, 0, 0, 0, 0, 1, 32'hCAFE_F00D, a_acc, i_acc);
        chk("collide_alu_held", {31'd0, a_acc}, 32'd0);
        chk("collide_load_first", {27'd0, rd_addr}, 32'd6);
        cycle(0, 1, 8, 32'h1234_5678, 0, 0, 0, 0, 0, 0, a_acc, i_acc);
        chk("collide_alu_next", {27'd0, rd_addr}, 32'd8);
        // Full queue, held fifth issue, then issue+response together
        cycle(0, 0, 0, 0, 1, 7, 3'b010, 0, 0, 0, a_acc, i_acc);
        cycle(0, 0, 0, 0, 1, 7, 3'b000, 1, 0, 0, a_acc, i_acc);
        cycle(0, 0, 0, 0, 1, 9, 3'b001, 2, 0, 0, a_acc, i_acc);
        cycle(0, 0, 0, 0, 1, 10, 3'b100, 3, 0, 0, a_acc, i_acc);
        cycle(0, 0, 0, 0, 1, 11, 3'b010, 0, 0, 0, a_acc, i_acc);
        chk("full_held", {31'd0, i_acc}, 32'd0);
        cycle(0, 0, 0, 0, 1, 11, 3'b010, 0, 1, 32'h1111_2222, a_acc, i_acc);
        chk("full_push_pop", {31'd0, i_acc}, 32'd1);
`ifdef WB_SCOREBOARD_EN
        chk("busy7_one_left", {31'd0, busy_mask[7]}, 32'd1);
`endif
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8765_4321, a_acc, i_acc);
`ifdef WB_SCOREBOARD_EN
        chk("busy7_cleared", {31'd0, busy_mask[7]}, 32'd0);
`endif
        for (int k = 0; k < 3; k++)
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5C3_7E81 + k, a_acc, i_acc);
        // x0 destinations and response with empty queue
        cycle(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 3'b010, 0, 0, 0, a_acc, i_acc);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA, a_acc, i_acc);
        chk("rd0_no_write", {31'd0, reg_write}, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD, a_acc, i_acc);
        chk("rsp_err_const", {31'd0, rsp_err}, 32'd1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, a_acc, i_acc);

        // Random traffic; the ALU/issue producers hold their request until accepted.
        r_av = 0; r_ard = 0; r_ares = 0; r_iv = 0; r_ird = 0; r_f3 = 0; r_lo = 0;
        a_acc = 1; i_acc = 1;
        for (int n = 0; n < 600; n++) begin
            if (a_acc || !r_av) begin
                r_av = ($urandom_range(0, 1) == 1);
                r_ard = 5'($urandom_range(0, 31));
                r_ares = $urandom;
            end
            if (i_acc || !r_iv) begin
                r_iv = ($urandom_range(0, 2) == 0);
                r_ird = 5'($urandom_range(0, 31));
                r_f3 = 3'($urandom_range(0, 7));
                r_lo = 2'($urandom_range(0, 3));
            end
            r_rv = ($urandom_range(0, 2) == 0) && (ldq.size() > 0 || $urandom_range(0, 40) == 0);
            cycle($urandom_range(0, 150) == 0, r_av, r_ard, r_ares, r_iv, r_ird, r_f3, r_lo,
                  r_rv, $urandom, a_acc, i_acc);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
